// File: rtl/squarer_pipe.sv
// Pipelined multi-lane squarer: each beat carries LANES packed operands plus a
// signed/unsigned flag and yields per-lane squares and their exact sum after STAGES cycles.
module squarer_pipe #(
    parameter int LANES  = 8,
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    localparam int SUM_W = 2*WIDTH + ((LANES > 1) ? $clog2(LANES) : 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_signed,
    input  logic [LANES*WIDTH-1:0]       data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*2*WIDTH-1:0]     data_out,
    output logic [SUM_W-1:0]             sum_out,
    output logic [31:0]                  xfer_count
);
    localparam int SQ_W  = 2*WIDTH;
    localparam int OUT_W = LANES*SQ_W;

    // Square via magnitude: |-2^(W-1)| = 2^(W-1) still fits in W unsigned bits.
    function automatic logic [SQ_W-1:0] square_lane(input logic [WIDTH-1:0] x,
                                                    input logic             is_signed);
        logic             neg;
        logic [WIDTH-1:0] mag;
        neg = is_signed & x[WIDTH-1];
        mag = neg ? ((~x) + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
        return {{WIDTH{1'b0}}, mag} * {{WIDTH{1'b0}}, mag};
    endfunction

    logic [OUT_W-1:0]              sq_p0_d;
    logic [SUM_W-1:0]              sum_p0_d;
    logic [STAGES-1:0]             vld_q;
    logic [STAGES-1:0][OUT_W-1:0]  sq_q;
    logic [STAGES-1:0][SUM_W-1:0]  sum_q;
    logic [31:0]                   xfer_count_q;
    logic [31:0]                   xfer_count_d;
    logic                          advance;
    logic                          accept;
    logic                          out_xfer;

    always_comb begin
        sq_p0_d  = '0;
        sum_p0_d = '0;
        for (int k = 0; k < LANES; k++) begin
            sq_p0_d[k*SQ_W +: SQ_W] = square_lane(data_in[k*WIDTH +: WIDTH], in_signed);
            sum_p0_d = sum_p0_d + {{(SUM_W-SQ_W){1'b0}}, sq_p0_d[k*SQ_W +: SQ_W]};
        end
    end

    // The whole pipe freezes only when the last stage holds a beat nobody takes.
    assign advance      = !(vld_q[STAGES-1] && !out_ready);
    assign in_ready     = !rst && advance;
    assign accept       = in_valid && in_ready;
    assign out_xfer     = vld_q[STAGES-1] && out_ready;
    assign xfer_count_d = out_xfer ? (xfer_count_q + 32'd1) : xfer_count_q;

    // Stage registers: data only loads behind a valid beat, so bubbles leave the last result in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q        <= '0;
            sq_q         <= '0;
            sum_q        <= '0;
            xfer_count_q <= '0;
        end else begin
            xfer_count_q <= xfer_count_d;
            if (advance) begin
                vld_q[0] <= accept;
                if (accept) begin
                    sq_q[0]  <= sq_p0_d;
                    sum_q[0] <= sum_p0_d;
                end
                for (int s = 1; s < STAGES; s++) begin
                    vld_q[s] <= vld_q[s-1];
                    if (vld_q[s-1]) begin
                        sq_q[s]  <= sq_q[s-1];
                        sum_q[s] <= sum_q[s-1];
                    end
                end
            end
        end
    end

    assign out_valid  = vld_q[STAGES-1];
    assign data_out   = sq_q[STAGES-1];
    assign sum_out    = sum_q[STAGES-1];
    assign xfer_count = xfer_count_q;

endmodule
